// File: rtl/rx_pkg.sv
// rx_pkg: shared state type, default sizes and timing helper for the serial frame receiver
//   Build option RX_PARITY_EN adds the PARITY state and moves the stop sample one bit later.
package rx_pkg;
   localparam int RX_DATA_W_DEF = 5;
   localparam int RX_OVS_DEF = 4;
`ifdef RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} rx_state_t;
`else
   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
`endif
   // cycles from t0 (first cycle the synchronised line is seen low) to the stop-bit sample
   function automatic int rx_stop_offset(input int data_w, input int ovs);
`ifdef RX_PARITY_EN
      return ovs / 2 + (data_w + 2) * ovs;
`else
      return ovs / 2 + (data_w + 1) * ovs;
`endif
   endfunction
endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: oversample cycle counter with bit-boundary and mid-bit flags
//   clk, rstn : clock, asynchronous active-low reset
//   en        : count while a frame is in progress
//   clr       : synchronous clear, wins over en
//   tc        : count == OVS-1, end of a bit period
//   mid       : count == OVS/2-1, centre of the start bit
module rx_bit_timer #(
   parameter int OVS = 4
) (
   input  logic clk,
   input  logic rstn,
   input  logic en,
   input  logic clr,
   output logic tc,
   output logic mid
);
   localparam int CW = $clog2(OVS);
   logic [CW-1:0] clk_cnt;
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) clk_cnt <= '0;
      else clk_cnt <= clr ? '0 : en ? clk_cnt + CW'(1) : clk_cnt;
   assign tc = clk_cnt == CW'(OVS - 1);
   assign mid = clk_cnt == CW'(OVS / 2 - 1);
endmodule

// File: rtl/rx_frame_receiver.sv
// rx_frame_receiver: oversampled serial frame receiver with start detection and valid/ready output
//   clk, rstn  : clock, asynchronous active-low reset
//   rx_data    : serial line, idles high, LSB first
//   rx_word    : received word, held while rx_valid
//   rx_valid   : word available until rx_valid && rx_ready
//   rx_ready   : consumer accept
//   frame_err  : one-cycle pulse, stop bit sampled low
//   overrun    : one-cycle pulse, completion while the previous word was unaccepted
//   busy       : receiver not idle
//   parity_err : one-cycle pulse with a completion whose parity is wrong (RX_PARITY_EN only)
//   Build option RX_PARITY_EN adds a parity bit between data and stop (parameter PARITY_ODD).
module rx_frame_receiver
   import rx_pkg::*;
#(
   parameter int DATA_W = RX_DATA_W_DEF,
   parameter int OVS = RX_OVS_DEF,
   parameter int SYNC_STAGES = 2
`ifdef RX_PARITY_EN
   , parameter bit PARITY_ODD = 1'b0
`endif
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              rx_data,
   output logic [DATA_W-1:0] rx_word,
   output logic              rx_valid,
   input  logic              rx_ready,
   output logic              frame_err,
   output logic              overrun,
`ifdef RX_PARITY_EN
   output logic              parity_err,
`endif
   output logic              busy
);
   localparam int BW = $clog2(DATA_W + 1);
   logic [SYNC_STAGES-1:0] sync;
   logic s, s_prev;
   rx_state_t state, state_nx;
   logic [BW-1:0] bit_cnt;
   logic [DATA_W-1:0] sh;
   logic tc, mid, cnt_clr, shift, bit_clr, done_ok, done_bad;
`ifdef RX_PARITY_EN
   logic par_load, par_bit;
`endif
   assign s = sync[SYNC_STAGES-1];
   assign busy = state != IDLE;
   rx_bit_timer #(.OVS(OVS)) u_timer (
      .clk (clk),
      .rstn(rstn),
      .en  (busy),
      .clr (cnt_clr),
      .tc  (tc),
      .mid (mid)
   );
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         sync <= '1;
         s_prev <= 1'b1;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], rx_data};
         s_prev <= s;
      end
   always_comb begin
      state_nx = state;
      cnt_clr = 1'b0;
      shift = 1'b0;
      bit_clr = 1'b0;
      done_ok = 1'b0;
      done_bad = 1'b0;
`ifdef RX_PARITY_EN
      par_load = 1'b0;
`endif
      case (state)
         IDLE:
            if (s_prev && !s) begin
               state_nx = START;
               cnt_clr = 1'b1;
            end
         START:
            if (mid) begin
               cnt_clr = 1'b1;
               bit_clr = 1'b1;
               state_nx = s ? IDLE : DATA;
            end
         DATA:
            if (tc) begin
               shift = 1'b1;
               cnt_clr = 1'b1;
`ifdef RX_PARITY_EN
               if (bit_cnt == BW'(DATA_W - 1)) state_nx = PARITY;
`else
               if (bit_cnt == BW'(DATA_W - 1)) state_nx = STOP;
`endif
            end
`ifdef RX_PARITY_EN
         PARITY:
            if (tc) begin
               par_load = 1'b1;
               cnt_clr = 1'b1;
               state_nx = STOP;
            end
`endif
         STOP:
            if (tc) begin
               cnt_clr = 1'b1;
               done_ok = s;
               done_bad = !s;
               state_nx = IDLE;
            end
         default: state_nx = IDLE;
      endcase
   end
   // rx_word only changes when the holding slot is free or being emptied this cycle
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         state <= IDLE;
         bit_cnt <= '0;
         sh <= '0;
         rx_word <= '0;
         rx_valid <= 1'b0;
         frame_err <= 1'b0;
         overrun <= 1'b0;
      end else begin
         state <= state_nx;
         bit_cnt <= bit_clr ? '0 : shift ? bit_cnt + BW'(1) : bit_cnt;
         if (shift) sh <= DATA_W'({s, sh} >> 1);
         if (done_ok && (!rx_valid || rx_ready)) rx_word <= sh;
         rx_valid <= done_ok | (rx_valid & ~rx_ready);
         frame_err <= done_bad;
         overrun <= done_ok & rx_valid & ~rx_ready;
      end
`ifdef RX_PARITY_EN
   always_ff @(posedge clk or negedge rstn)
      if (!rstn) begin
         par_bit <= 1'b0;
         parity_err <= 1'b0;
      end else begin
         if (par_load) par_bit <= s;
         parity_err <= done_ok & ((^{sh, par_bit}) != PARITY_ODD);
      end
`endif
endmodule

// File: tb/tb_rx_frame_receiver.sv
// tb_rx_frame_receiver: frame-level stimulus with an event-queue reference model
module tb_rx_frame_receiver;
   import rx_pkg::*;
   localparam int DW = RX_DATA_W_DEF;
   localparam int OVS = RX_OVS_DEF;
   localparam int SYNC = 2;
   localparam int STOP_OFF = rx_stop_offset(DW, OVS);
   localparam int LAT = SYNC + 1 + STOP_OFF;
`ifdef RX_PARITY_EN
   localparam int FRAME_LEN = (DW + 3) * OVS;
`else
   localparam int FRAME_LEN = (DW + 2) * OVS;
`endif
   logic clk = 1'b0, rstn = 1'b0, rx_data = 1'b1, rx_ready = 1'b0;
   logic [DW-1:0] rx_word;
   logic rx_valid, frame_err, overrun, busy;
`ifdef RX_PARITY_EN
   logic parity_err;
`endif
   rx_frame_receiver #(.DATA_W(DW), .OVS(OVS), .SYNC_STAGES(SYNC)) dut (
      .clk      (clk),
      .rstn     (rstn),
      .rx_data  (rx_data),
      .rx_word  (rx_word),
      .rx_valid (rx_valid),
      .rx_ready (rx_ready),
      .frame_err(frame_err),
      .overrun  (overrun),
`ifdef RX_PARITY_EN
      .parity_err(parity_err),
`endif
      .busy     (busy)
   );
   always #5 clk = ~clk;
   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end
   // kind: 0 good frame, 1 stop bit low, 2 start glitch
   typedef struct {
      int at;
      int b_lo;
      int b_hi;
      int last;
      int kind;
      logic [DW-1:0] word;
      logic perr;
   } ev_t;
   typedef struct {
      logic [DW-1:0] data;
      logic stop;
      logic [DW-1:0] exp_word;
      logic exp_valid;
      int exp_ferr;
   } vec_t;
   int vectors = 0, miscompares = 0, cyc = 0;
   logic pin_q[$];
   ev_t ev_q[$];
   logic model_on = 1'b0;
   logic m_valid = 1'b0, m_ovr = 1'b0, m_ferr = 1'b0;
   logic [DW-1:0] m_word = '0;
   int obs_vcyc, n_ferr, n_ovr, n_busy, n_perr;
   logic [DW-1:0] obs_word;
   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, exp);
      end
   endtask
   task automatic clear_obs();
      obs_vcyc = -1;
      obs_word = '0;
      n_ferr = 0;
      n_ovr = 0;
      n_busy = 0;
      n_perr = 0;
   endtask
   task automatic send_frame(input logic [DW-1:0] d, input logic stop, input logic pflip, output int k);
      ev_t e;
      k = cyc + pin_q.size() + 1;
      repeat (OVS) pin_q.push_back(1'b0);
      for (int i = 0; i < DW; i++) repeat (OVS) pin_q.push_back(d[i]);
`ifdef RX_PARITY_EN
      repeat (OVS) pin_q.push_back(^d ^ pflip);
`endif
      repeat (OVS) pin_q.push_back(stop);
      e.at = k + LAT;
      e.b_lo = k + SYNC + 1;
      e.b_hi = k + SYNC + STOP_OFF;
      e.last = e.at;
      e.kind = stop ? 0 : 1;
      e.word = d;
      e.perr = pflip;
      ev_q.push_back(e);
   endtask
   task automatic send_glitch(output int k);
      ev_t e;
      k = cyc + pin_q.size() + 1;
      pin_q.push_back(1'b0);
      pin_q.push_back(1'b1);
      e.at = -1;
      e.b_lo = k + SYNC + 1;
      e.b_hi = k + SYNC + OVS / 2;
      e.last = e.b_hi;
      e.kind = 2;
      e.word = '0;
      e.perr = 1'b0;
      ev_q.push_back(e);
   endtask
   // one clock: update the model, compare, then drive the next line level
   task automatic step();
      logic comp, bad, perr, bsy, rp;
      logic [DW-1:0] w;
      rp = rx_ready;
      @(posedge clk);
      #1;
      cyc++;
      comp = 1'b0;
      bad = 1'b0;
      perr = 1'b0;
      bsy = 1'b0;
      w = '0;
      foreach (ev_q[i]) begin
         if (ev_q[i].at == cyc) begin
            comp = ev_q[i].kind == 0;
            bad = ev_q[i].kind == 1;
            w = ev_q[i].word;
            perr = ev_q[i].perr;
         end
         if (cyc >= ev_q[i].b_lo && cyc <= ev_q[i].b_hi) bsy = 1'b1;
      end
      while (ev_q.size() > 0 && ev_q[0].last <= cyc) ev_q.delete(0);
      if (m_valid && rp) m_valid = 1'b0;
      m_ovr = 1'b0;
      if (comp) begin
         if (m_valid) m_ovr = 1'b1;
         else m_word = w;
         m_valid = 1'b1;
      end
      m_ferr = bad;
      if (model_on) begin
         check("rx_valid", rx_valid, m_valid);
         check("rx_word", rx_word, m_word);
         check("frame_err", frame_err, m_ferr);
         check("overrun", overrun, m_ovr);
         check("busy", busy, bsy);
`ifdef RX_PARITY_EN
         check("parity_err", parity_err, comp && perr);
`endif
      end
      if (rx_valid && obs_vcyc < 0) begin
         obs_vcyc = cyc;
         obs_word = rx_word;
      end
      n_ferr += frame_err;
      n_ovr += overrun;
      n_busy += busy;
`ifdef RX_PARITY_EN
      n_perr += parity_err;
`endif
      rx_data = pin_q.size() > 0 ? pin_q.pop_front() : 1'b1;
   endtask
   initial begin
      vec_t tbl[9];
      int k;
      tbl[0] = '{5'h16, 1'b1, 5'h16, 1'b1, 0};
      tbl[1] = '{5'h16, 1'b0, 5'h00, 1'b0, 1};
      tbl[2] = '{5'h16, 1'b1, 5'h16, 1'b1, 0};
      tbl[3] = '{5'h00, 1'b1, 5'h00, 1'b1, 0};
      tbl[4] = '{5'h1F, 1'b1, 5'h1F, 1'b1, 0};
      tbl[5] = '{5'h09, 1'b1, 5'h09, 1'b1, 0};
      tbl[6] = '{5'h01, 1'b1, 5'h01, 1'b1, 0};
      tbl[7] = '{5'h10, 1'b0, 5'h00, 1'b0, 1};
      tbl[8] = '{5'h10, 1'b1, 5'h10, 1'b1, 0};
      clear_obs();
      repeat (3) step();
      check("reset rx_word", rx_word, 0);
      check("reset rx_valid", rx_valid, 0);
      check("reset frame_err", frame_err, 0);
      check("reset overrun", overrun, 0);
      check("reset busy", busy, 0);
      rstn = 1'b1;
      model_on = 1'b1;
      repeat (4) step();
      rx_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         clear_obs();
         send_frame(tbl[i].data, tbl[i].stop, 1'b0, k);
         repeat (LAT + 4) step();
         check("tbl valid seen", obs_vcyc >= 0, tbl[i].exp_valid);
         check("tbl word", obs_word, tbl[i].exp_word);
         check("tbl frame_err pulses", n_ferr, tbl[i].exp_ferr);
         if (tbl[i].exp_valid) check("tbl latency", obs_vcyc - k, LAT);
      end
      clear_obs();
      send_glitch(k);
      repeat (16) step();
      check("glitch busy cycles", n_busy, 2);
      check("glitch valid seen", obs_vcyc >= 0, 0);
      check("glitch frame_err", n_ferr, 0);
      rx_ready = 1'b0;
      clear_obs();
      send_frame(5'h16, 1'b1, 1'b0, k);
      send_frame(5'h09, 1'b1, 1'b0, k);
      repeat (FRAME_LEN + LAT + 4) step();
      check("overrun word kept", rx_word, 5'h16);
      check("overrun pulses", n_ovr, 1);
      check("overrun valid held", rx_valid, 1);
      rx_ready = 1'b1;
      step();
      step();
      check("overrun valid cleared", rx_valid, 0);
      rx_ready = 1'b0;
      send_frame(5'h0A, 1'b1, 1'b0, k);
      repeat (LAT + 2) step();
      send_frame(5'h15, 1'b1, 1'b0, k);
      repeat (SYNC + OVS / 2 + 2 * OVS + 3) step();
      check("pre-reset busy", busy, 1);
      check("pre-reset valid", rx_valid, 1);
      rstn = 1'b0;
      #1;
      check("async reset rx_valid", rx_valid, 0);
      check("async reset rx_word", rx_word, 0);
      check("async reset busy", busy, 0);
      check("async reset frame_err", frame_err, 0);
      check("async reset overrun", overrun, 0);
      model_on = 1'b0;
      ev_q.delete();
      pin_q.delete();
      m_valid = 1'b0;
      m_word = '0;
      rx_data = 1'b1;
      repeat (3) step();
      rstn = 1'b1;
      repeat (3) step();
      model_on = 1'b1;
      rx_ready = 1'b1;
      clear_obs();
      send_frame(5'h1F, 1'b1, 1'b0, k);
      repeat (LAT + 4) step();
      check("post-reset word", obs_word, 5'h1F);
      check("post-reset latency", obs_vcyc - k, LAT);
      check("post-reset frame_err", n_ferr, 0);
`ifdef RX_PARITY_EN
      clear_obs();
      send_frame(5'h16, 1'b1, 1'b1, k);
      repeat (LAT + 4) step();
      check("parity err pulses", n_perr, 1);
      check("parity word delivered", obs_word, 5'h16);
`endif
      for (int f = 0; f < 40; f++) begin
         logic st, pf;
         st = $urandom_range(0, 7) != 0;
         pf = 1'b0;
`ifdef RX_PARITY_EN
         pf = 1'($urandom_range(0, 1));
`endif
         send_frame(DW'($urandom), st, pf, k);
         repeat ($urandom_range(st ? 0 : 1, 3)) pin_q.push_back(1'b1);
      end
      while (pin_q.size() > 0 || ev_q.size() > 0) begin
         rx_ready = 1'($urandom_range(0, 1));
         step();
      end
      rx_ready = 1'b1;
      repeat (4) step();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
